// File: rtl/cart_bus_pkg.sv
// Shared cart bus definitions for the save loader and save dumper.
package cart_bus_pkg;

  // Bit positions inside cart_tran_bank0_out[7:4] = {1'b0, WR_n, RD_n, CS}
  localparam int unsigned WR_N = 6;
  localparam int unsigned RD_N = 5;
  localparam int unsigned CS   = 4;

  // Bank0 value with the bus released: WR_n=1, RD_n=1, CS=0
  localparam logic [3:0] BANK0_IDLE = 4'b0110;

  localparam logic [15:0] RAM_BASE        = 16'hA000;
  localparam logic [15:0] BANK_REG_ADDR   = 16'h4000;
  localparam logic [15:0] ENABLE_REG_ADDR = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENABLE,
    ST_BANK,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } cart_state_e;

  // Down-counter load value for a phase of n cycles; a length of 0 runs as 1
  function automatic logic [7:0] phase_load(input logic [7:0] n);
    return (n == 8'd0) ? 8'd0 : n - 8'd1;
  endfunction

endpackage

// File: rtl/cart_write_cycle.sv
// One cart bus write: SETUP with address/data driven, WR_n strobe, one HOLD cycle.
module cart_write_cycle
  import cart_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 4
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] address,
  input  logic [7:0]  data,
  input  logic        is_sram,
  input  logic [7:0]  strobe_len,
  output logic        done_c,
  output logic [15:0] cart_address,
  output logic [7:4]  cart_tran_bank0_out,
  output logic [7:0]  cart_tran_bank1_out,
  output logic        cart_tran_bank1_dir
);

  localparam logic [7:0] SETUP_LOAD = phase_load(8'(SETUP_CYCLES));

  cart_state_e phase;
  logic [7:0]  cnt;
  logic [7:0]  strobe_q;

  // Last cycle of the bus cycle; the caller advances on the same edge HOLD ends
  assign done_c = (phase == ST_HOLD);

  // Phase sequencing and registered pin drive
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      phase               <= ST_IDLE;
      cnt                 <= 8'd0;
      strobe_q            <= 8'd0;
      cart_address        <= 16'd0;
      cart_tran_bank0_out <= BANK0_IDLE;
      cart_tran_bank1_out <= 8'd0;
      cart_tran_bank1_dir <= 1'b0;
    end else begin
      case (phase)
        ST_IDLE: begin
          if (start) begin
            phase                   <= ST_SETUP;
            cnt                     <= SETUP_LOAD;
            strobe_q                <= phase_load(strobe_len);
            cart_address            <= address;
            cart_tran_bank1_out     <= data;
            cart_tran_bank1_dir     <= 1'b1;
            cart_tran_bank0_out[CS] <= is_sram;
          end
        end
        ST_SETUP: begin
          if (cnt == 8'd0) begin
            phase                     <= ST_STROBE;
            cnt                       <= strobe_q;
            cart_tran_bank0_out[WR_N] <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_STROBE: begin
          if (cnt == 8'd0) begin
            phase                     <= ST_HOLD;
            cart_tran_bank0_out[WR_N] <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_HOLD: begin
          // Release the data bus and deselect; last data byte stays on bank1_out
          phase                   <= ST_IDLE;
          cart_tran_bank1_dir     <= 1'b0;
          cart_tran_bank0_out[CS] <= 1'b0;
        end
        default: phase <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/save_loader.sv
// Restores a cartridge save: bridge byte writes become MBC setup and SRAM writes.
module save_loader
  import cart_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES      = 4,
  parameter int unsigned STROBE_CYCLES     = 16,
  parameter int unsigned REG_STROBE_CYCLES = 64,
  parameter logic [15:0] RAM_BASE          = cart_bus_pkg::RAM_BASE,
  parameter logic [15:0] BANK_REG_ADDR     = cart_bus_pkg::BANK_REG_ADDR,
  parameter logic [15:0] ENABLE_REG_ADDR   = cart_bus_pkg::ENABLE_REG_ADDR,
  parameter logic [7:0]  ENABLE_VALUE      = 8'h0A
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_8bit_addr,
  input  logic [7:0]  bridge_8bit_wr_data,
  input  logic        overflow_clr,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] cart_address,
  output logic [7:4]  cart_tran_bank0_out,
  output logic [7:0]  cart_tran_bank1_out,
  output logic        cart_tran_bank1_dir
);

  localparam logic [7:0] SRAM_STROBE_LEN = 8'(STROBE_CYCLES);
  localparam logic [7:0] REG_STROBE_LEN  = 8'(REG_STROBE_CYCLES);

  logic        prev_bridge_wr;
  logic        hold_valid;
  logic [20:0] hold_addr;
  logic [7:0]  hold_data;
  logic        ram_enabled;
  logic [7:0]  cur_bank;
  cart_state_e state;

  logic        cw_start;
  logic [15:0] cw_addr;
  logic [7:0]  cw_data;
  logic        cw_is_sram;
  logic [7:0]  cw_strobe;
  logic        cw_done_c;

  logic        wr_edge_c;
  logic [7:0]  hold_bank_c;
  logic        free_c;
  logic        accept_c;
  logic        drop_c;
  logic [10:0] addr_unused;

  // Offsets beyond 2 MiB alias onto the 256-bank window
  assign addr_unused = bridge_8bit_addr[31:21];

  assign wr_edge_c   = bridge_wr & ~prev_bridge_wr;
  assign hold_bank_c = hold_addr[20:13];
  // Holding register empties as its SRAM write is launched, so a byte on that edge still fits
  assign free_c      = (state == ST_IDLE) && hold_valid && ram_enabled && (hold_bank_c == cur_bank);
  assign accept_c    = wr_edge_c && (!hold_valid || free_c);
  assign drop_c      = wr_edge_c && hold_valid && !free_c;

  // Bridge edge capture, holding register, overflow and busy flags
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      prev_bridge_wr <= 1'b0;
      hold_valid     <= 1'b0;
      hold_addr      <= 21'd0;
      hold_data      <= 8'd0;
      overflow       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      prev_bridge_wr <= bridge_wr;

      if (accept_c) begin
        hold_valid <= 1'b1;
        hold_addr  <= bridge_8bit_addr[20:0];
        hold_data  <= bridge_8bit_wr_data;
      end else if (free_c) begin
        hold_valid <= 1'b0;
      end

      if (drop_c) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end

      if (cw_done_c) begin
        busy <= hold_valid | wr_edge_c;
      end else if (wr_edge_c) begin
        busy <= 1'b1;
      end
    end
  end

  // Sequencer: decide which bus cycle the held byte needs next and track MBC state
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ram_enabled <= 1'b0;
      cur_bank    <= 8'hFF;
      cw_start    <= 1'b0;
      cw_addr     <= 16'd0;
      cw_data     <= 8'd0;
      cw_is_sram  <= 1'b0;
      cw_strobe   <= 8'd0;
    end else begin
      cw_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hold_valid) begin
            cw_start <= 1'b1;
            if (!ram_enabled) begin
              state      <= ST_ENABLE;
              cw_addr    <= ENABLE_REG_ADDR;
              cw_data    <= ENABLE_VALUE;
              cw_is_sram <= 1'b0;
              cw_strobe  <= REG_STROBE_LEN;
            end else if (hold_bank_c != cur_bank) begin
              state      <= ST_BANK;
              cw_addr    <= BANK_REG_ADDR;
              cw_data    <= hold_bank_c;
              cw_is_sram <= 1'b0;
              cw_strobe  <= REG_STROBE_LEN;
            end else begin
              // 13-bit offset into the 8 KiB window; never carries past the window
              state      <= ST_SETUP;
              cw_addr    <= RAM_BASE + 16'(hold_addr[12:0]);
              cw_data    <= hold_data;
              cw_is_sram <= 1'b1;
              cw_strobe  <= SRAM_STROBE_LEN;
            end
          end
        end
        ST_ENABLE: begin
          if (cw_done_c) begin
            ram_enabled <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_BANK: begin
          if (cw_done_c) begin
            cur_bank <= hold_bank_c;
            state    <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cw_done_c) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cart_write_cycle #(
    .SETUP_CYCLES(SETUP_CYCLES)
  ) u_cycle (
    .clk_74a             (clk_74a),
    .reset_n             (reset_n),
    .start               (cw_start),
    .address             (cw_addr),
    .data                (cw_data),
    .is_sram             (cw_is_sram),
    .strobe_len          (cw_strobe),
    .done_c              (cw_done_c),
    .cart_address        (cart_address),
    .cart_tran_bank0_out (cart_tran_bank0_out),
    .cart_tran_bank1_out (cart_tran_bank1_out),
    .cart_tran_bank1_dir (cart_tran_bank1_dir)
  );

endmodule

// File: tb/tb_save_loader.sv
// Directed bench for save_loader: records every WR_n strobe and compares against expected cart writes.
module tb_save_loader;

  logic        clk;
  logic        reset_n;
  logic        bridge_wr;
  logic [31:0] bridge_8bit_addr;
  logic [7:0]  bridge_8bit_wr_data;
  logic        overflow_clr;
  logic        busy;
  logic        overflow;
  logic [15:0] cart_address;
  logic [7:4]  cart_tran_bank0_out;
  logic [7:0]  cart_tran_bank1_out;
  logic        cart_tran_bank1_dir;

  int total = 0;
  int bad   = 0;
  int rd_bad = 0;

  // Record = {address, data, CS, dir, WR_n low width}
  logic [33:0] mon_q[$];

  save_loader dut (
    .clk_74a             (clk),
    .reset_n             (reset_n),
    .bridge_wr           (bridge_wr),
    .bridge_8bit_addr    (bridge_8bit_addr),
    .bridge_8bit_wr_data (bridge_8bit_wr_data),
    .overflow_clr        (overflow_clr),
    .busy                (busy),
    .overflow            (overflow),
    .cart_address        (cart_address),
    .cart_tran_bank0_out (cart_tran_bank0_out),
    .cart_tran_bank1_out (cart_tran_bank1_out),
    .cart_tran_bank1_dir (cart_tran_bank1_dir)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe monitor: samples on the falling edge, records each completed WR_n low pulse
  initial begin : monitor
    logic        in_low;
    logic        prev_wr;
    logic [7:0]  width;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    logic        m_cs;
    logic        m_dir;
    in_low  = 1'b0;
    prev_wr = 1'b1;
    width   = 8'd0;
    m_addr  = 16'd0;
    m_data  = 8'd0;
    m_cs    = 1'b0;
    m_dir   = 1'b0;
    forever begin
      @(negedge clk);
      if (cart_tran_bank0_out[5] !== 1'b1) rd_bad++;
      if (!reset_n) begin
        in_low  = 1'b0;
        prev_wr = 1'b1;
      end else begin
        if (in_low) begin
          if (cart_tran_bank0_out[6] == 1'b0) begin
            width = width + 8'd1;
          end else begin
            mon_q.push_back({m_addr, m_data, m_cs, m_dir, width});
            in_low = 1'b0;
          end
        end else if (cart_tran_bank0_out[6] == 1'b0 && prev_wr == 1'b1) begin
          in_low = 1'b1;
          width  = 8'd1;
          m_addr = cart_address;
          m_data = cart_tran_bank1_out;
          m_cs   = cart_tran_bank0_out[4];
          m_dir  = cart_tran_bank1_dir;
        end
        prev_wr = cart_tran_bank0_out[6];
      end
    end
  end

  function automatic logic [33:0] rec(input logic [15:0] a, input logic [7:0] d,
                                      input logic cs, input logic [7:0] w);
    return {a, d, cs, 1'b1, w};
  endfunction

  task automatic bridge_write(input logic [31:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bridge_8bit_addr    = a;
    bridge_8bit_wr_data = d;
    bridge_wr           = 1'b1;
    @(posedge clk); #1;
    bridge_wr = 1'b0;
  endtask

  // Bounded wait for busy to drop; an expired bound counts as a failure
  task automatic wait_idle(input string name);
    int n;
    repeat (2) @(posedge clk);
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s idle_timeout busy=%0b after %0d cycles", name, busy, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (cart_tran_bank0_out !== 4'b0110) begin bad++; $display("FAIL reset_bank0 got=%b exp=0110", cart_tran_bank0_out); end
    total++; if (cart_address !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", cart_address); end
    total++; if (cart_tran_bank1_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", cart_tran_bank1_out); end
    total++; if (cart_tran_bank1_dir !== 1'b0) begin bad++; $display("FAIL reset_dir got=%b exp=0", cart_tran_bank1_dir); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_first_write();
    logic [33:0] exp[3];
    logic [33:0] got;
    exp[0] = rec(16'h0000, 8'h0A, 1'b0, 8'd64);
    exp[1] = rec(16'h4000, 8'h00, 1'b0, 8'd64);
    exp[2] = rec(16'hA000, 8'h5A, 1'b1, 8'd16);
    mon_q.delete();
    bridge_write(32'h0000_0000, 8'h5A);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_busy_rise got=%b exp=1", busy); end
    wait_idle("first_write");
    total++; if (mon_q.size() != 3) begin bad++; $display("FAIL first_count got=%0d exp=3", mon_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 34'd0;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL first_rec%0d got=%h exp=%h", i, got, exp[i]); end
    end
    total++; if (cart_tran_bank1_dir !== 1'b0) begin bad++; $display("FAIL first_release_dir got=%b exp=0", cart_tran_bank1_dir); end
    total++; if (cart_tran_bank0_out !== 4'b0110) begin bad++; $display("FAIL first_release_bank0 got=%b exp=0110", cart_tran_bank0_out); end
  endtask

  task automatic test_same_bank();
    logic [33:0] got;
    mon_q.delete();
    bridge_write(32'h0000_0001, 8'h33);
    wait_idle("same_bank");
    total++; if (mon_q.size() != 1) begin bad++; $display("FAIL same_bank_count got=%0d exp=1", mon_q.size()); end
    got = (mon_q.size() > 0) ? mon_q[0] : 34'd0;
    total++; if (got !== rec(16'hA001, 8'h33, 1'b1, 8'd16)) begin bad++; $display("FAIL same_bank_rec got=%h exp=%h", got, rec(16'hA001, 8'h33, 1'b1, 8'd16)); end
  endtask

  task automatic test_bank_switch();
    logic [33:0] exp[2];
    logic [33:0] got;
    exp[0] = rec(16'h4000, 8'h01, 1'b0, 8'd64);
    exp[1] = rec(16'hA000, 8'h77, 1'b1, 8'd16);
    mon_q.delete();
    bridge_write(32'h0000_2000, 8'h77);
    wait_idle("bank_switch");
    total++; if (mon_q.size() != 2) begin bad++; $display("FAIL bank_switch_count got=%0d exp=2", mon_q.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 34'd0;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL bank_switch_rec%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  task automatic test_window_edges();
    logic [33:0] exp[4];
    logic [33:0] got;
    exp[0] = rec(16'hBFFF, 8'hC3, 1'b1, 8'd16);
    exp[1] = rec(16'h4000, 8'h00, 1'b0, 8'd64);
    exp[2] = rec(16'hA000, 8'h11, 1'b1, 8'd16);
    exp[3] = rec(16'hA005, 8'hE7, 1'b1, 8'd16);
    mon_q.delete();
    bridge_write(32'h0000_3FFF, 8'hC3);
    wait_idle("no_carry");
    bridge_write(32'h0000_0000, 8'h11);
    wait_idle("reselect_bank0");
    bridge_write(32'h0020_0005, 8'hE7);
    wait_idle("high_bits_ignored");
    total++; if (mon_q.size() != 4) begin bad++; $display("FAIL window_count got=%0d exp=4", mon_q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 34'd0;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL window_rec%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [33:0] exp[2];
    logic [33:0] got;
    exp[0] = rec(16'hA010, 8'hD0, 1'b1, 8'd16);
    exp[1] = rec(16'hA011, 8'hD1, 1'b1, 8'd16);
    mon_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bridge_8bit_addr    = 32'h10 + 32'(i);
      bridge_8bit_wr_data = 8'hD0 + 8'(i);
      bridge_wr           = 1'b1;
      @(posedge clk); #1;
      bridge_wr = 1'b0;
    end
    @(negedge clk);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_set got=%b exp=1", overflow); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL overflow_busy got=%b exp=1", busy); end
    wait_idle("overflow");
    total++; if (mon_q.size() != 2) begin bad++; $display("FAIL overflow_count got=%0d exp=2", mon_q.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 34'd0;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL overflow_rec%0d got=%h exp=%h", i, got, exp[i]); end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
    @(posedge clk); #1;
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    @(negedge clk);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_mid_write();
    logic [33:0] exp[3];
    logic [33:0] got;
    int n;
    exp[0] = rec(16'h0000, 8'h0A, 1'b0, 8'd64);
    exp[1] = rec(16'h4000, 8'h01, 1'b0, 8'd64);
    exp[2] = rec(16'hA000, 8'h44, 1'b1, 8'd16);
    bridge_write(32'h0000_0001, 8'h99);
    n = 0;
    @(negedge clk);
    while (cart_tran_bank0_out[6] !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++; if (cart_tran_bank0_out[6] !== 1'b0) begin bad++; $display("FAIL midreset_strobe_timeout wr_n=%b exp=0", cart_tran_bank0_out[6]); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (cart_tran_bank0_out[6] !== 1'b1) begin bad++; $display("FAIL midreset_wr_n got=%b exp=1", cart_tran_bank0_out[6]); end
    total++; if (cart_tran_bank1_dir !== 1'b0) begin bad++; $display("FAIL midreset_dir got=%b exp=0", cart_tran_bank1_dir); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    total++; if (cart_tran_bank0_out !== 4'b0110) begin bad++; $display("FAIL midreset_bank0 got=%b exp=0110", cart_tran_bank0_out); end
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    mon_q.delete();
    bridge_write(32'h0000_2000, 8'h44);
    wait_idle("after_reset");
    total++; if (mon_q.size() != 3) begin bad++; $display("FAIL after_reset_count got=%0d exp=3", mon_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 34'd0;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL after_reset_rec%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  initial begin
    reset_n             = 1'b0;
    bridge_wr           = 1'b0;
    bridge_8bit_addr    = 32'd0;
    bridge_8bit_wr_data = 8'd0;
    overflow_clr        = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    #2;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    test_first_write();
    test_same_bank();
    test_bank_switch();
    test_window_edges();
    test_overflow();
    test_reset_mid_write();
    total++;
    if (rd_bad != 0) begin bad++; $display("FAIL rd_n_high got=%0d low_samples exp=0", rd_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
